// File: rtl/mips_bus_pkg.sv
// rtl/mips_bus_pkg.sv - shared types and helpers for the MIPS shared-bus adapter
// Purpose: sequencer state encoding and the bus lane-alignment helper.
// Ports: none (package).

package mips_bus_pkg;

    typedef enum logic [2:0] {
        ST_RST,
        ST_FETCH,
        ST_FETCH_RESP,
        ST_DATA,
        ST_DATA_RESP,
        ST_STEP,
        ST_HALT
    } bus_state_t;

    // Clears the byte-lane offset bits of an address. Addresses wider than
    // 64 bits are not supported; callers zero-extend into the 64-bit argument.
    function automatic logic [63:0] lane_align(input logic [63:0]   addr,
                                               input int unsigned   lane_bits);
        return addr & ~((64'd1 << lane_bits) - 64'd1);
    endfunction

endpackage

// File: rtl/mips_bus_adapter.sv
// rtl/mips_bus_adapter.sv - runs a single-cycle Harvard MIPS core on one shared wait-stated bus
// Purpose: serialises each core step into an instruction fetch plus an
//   optional data access, freezing the core via core_clk_enable until both
//   complete, and latches the read data for the core's read ports.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   core_*                          core-side fetch/data ports, clk_enable, active
//   address/read/write/byteenable/
//   writedata/waitrequest/readdata  shared memory bus master
//   err                             sticky flag: core strobed read and write together
//   step_count, stall_count         retired steps, frozen-while-active cycles

module mips_bus_adapter
    import mips_bus_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  core_active,
    output logic                  core_clk_enable,
    input  logic [ADDR_W-1:0]     core_instr_address,
    output logic [DATA_W-1:0]     core_instr_readdata,
    input  logic [ADDR_W-1:0]     core_data_address,
    input  logic                  core_data_read,
    input  logic                  core_data_write,
    input  logic [DATA_W/8-1:0]   core_data_byteenable,
    input  logic [DATA_W-1:0]     core_data_writedata,
    output logic [DATA_W-1:0]     core_data_readdata,

    output logic [ADDR_W-1:0]     address,
    output logic                  read,
    output logic                  write,
    output logic [DATA_W/8-1:0]   byteenable,
    output logic [DATA_W-1:0]     writedata,
    input  logic                  waitrequest,
    input  logic [DATA_W-1:0]     readdata,

    output logic                  err,
    output logic [CNT_W-1:0]      step_count,
    output logic [CNT_W-1:0]      stall_count
);

    localparam int          BE_W      = DATA_W / 8;
    localparam int unsigned LANE_BITS = $clog2(BE_W);

    function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
        return ADDR_W'(lane_align(64'(a), LANE_BITS));
    endfunction

    bus_state_t          state_q;
    logic                read_q;
    logic                write_q;
    logic                cke_q;
    logic                err_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [BE_W-1:0]     be_q;
    logic [DATA_W-1:0]   wd_q;
    logic [DATA_W-1:0]   instr_q;
    logic [DATA_W-1:0]   data_q;
    logic [CNT_W-1:0]    step_q;
    logic [CNT_W-1:0]    stall_q;

    logic                data_req;
    assign data_req = core_data_read | core_data_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RST;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            cke_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wd_q    <= '0;
            instr_q <= '0;
            data_q  <= '0;
            step_q  <= '0;
            stall_q <= '0;
        end else begin
            if (core_active && state_q != ST_STEP) begin
                stall_q <= stall_q + CNT_W'(1);
            end

            case (state_q)
                ST_RST: begin
                    state_q <= ST_FETCH;
                    read_q  <= 1'b1;
                    be_q    <= '1;
                end

                ST_FETCH: begin
                    if (!waitrequest) begin
                        read_q  <= 1'b0;
                        state_q <= ST_FETCH_RESP;
                    end
                end

                ST_FETCH_RESP: begin
                    instr_q <= readdata;
                    // The core decodes the bypassed readdata this cycle, so
                    // its data strobes already reflect the new instruction.
                    if (data_req) begin
                        state_q <= ST_DATA;
                        addr_q  <= align(core_data_address);
                        be_q    <= core_data_byteenable;
                        write_q <= core_data_write;
                        read_q  <= ~core_data_write;
                        if (core_data_write) begin
                            wd_q <= core_data_writedata;
                        end
                        if (core_data_read && core_data_write) begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_STEP;
                        cke_q   <= 1'b1;
                    end
                end

                ST_DATA: begin
                    if (!waitrequest) begin
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                        if (write_q) begin
                            state_q <= ST_STEP;
                            cke_q   <= 1'b1;
                        end else begin
                            state_q <= ST_DATA_RESP;
                        end
                    end
                end

                ST_DATA_RESP: begin
                    data_q  <= readdata;
                    state_q <= ST_STEP;
                    cke_q   <= 1'b1;
                end

                ST_STEP: begin
                    cke_q  <= 1'b0;
                    step_q <= step_q + CNT_W'(1);
                    if (!core_active) begin
                        state_q <= ST_HALT;
                    end else begin
                        state_q <= ST_FETCH;
                        read_q  <= 1'b1;
                        be_q    <= '1;
                    end
                end

                ST_HALT: begin
                    state_q <= ST_HALT;
                end

                default: begin
                    state_q <= ST_RST;
                end
            endcase
        end
    end

    // The core's PC only moves on the clk_enable edge, so it is frozen for the
    // whole fetch; driving it through here avoids presenting the stale PC a
    // register captured on that same edge would hold.
    assign address = (state_q == ST_FETCH) ? align(core_instr_address) : addr_q;

    // Instruction bypass in FETCH_RESP lets the core decide on a data access
    // without spending an extra cycle.
    assign core_instr_readdata = (state_q == ST_FETCH_RESP) ? readdata : instr_q;

    assign read               = read_q;
    assign write              = write_q;
    assign byteenable         = be_q;
    assign writedata          = wd_q;
    assign core_clk_enable    = cke_q;
    assign core_data_readdata = data_q;
    assign err                = err_q;
    assign step_count         = step_q;
    assign stall_count        = stall_q;

endmodule
